// File: rtl/regfile_read.sv
// Register file terminating the write-back path: two registered read ports,
// one write port, and a per-register pending scoreboard that stalls reads
// of registers whose write-back is reserved but not yet performed.
module regfile_read #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] indata,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              stall,
  output logic [DATA_W-1:0] outdata_a,
  output logic [DATA_W-1:0] outdata_b,
  output logic              rd_valid
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_nxt;

  logic              hit_a;
  logic              hit_b;
  logic              pend_a;
  logic              pend_b;
  logic              rd_accept;
  logic [DATA_W-1:0] oper_a;
  logic [DATA_W-1:0] oper_b;

  // Write-port address matches and bypassed operand selection.
  always_comb begin
    hit_a  = wr_en && (wr_addr == rd_addr_a);
    hit_b  = wr_en && (wr_addr == rd_addr_b);
    oper_a = hit_a ? indata : regs[rd_addr_a];
    oper_b = hit_b ? indata : regs[rd_addr_b];
  end

  // A write presented this cycle clears the hazard on its target immediately.
  always_comb begin
    pend_a    = pending[rd_addr_a] && !hit_a;
    pend_b    = pending[rd_addr_b] && !hit_b;
    stall     = rd_en && (pend_a || pend_b);
    rd_accept = rd_en && !(pend_a || pend_b);
  end

  // Next scoreboard: write clears, reservation sets; reservation wins on a tie.
  always_comb begin
    pending_nxt = pending;
    if (wr_en) begin
      pending_nxt[wr_addr] = 1'b0;
    end
    if (rsv_en) begin
      pending_nxt[rsv_addr] = 1'b1;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // Register storage write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= indata;
    end
  end

  // Registered operands; hold when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outdata_a <= '0;
      outdata_b <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        outdata_a <= oper_a;
        outdata_b <= oper_b;
      end
    end
  end

endmodule

// File: tb/tb_regfile_read.sv
// Directed bench for regfile_read with a per-cycle response scoreboard.
module tb_regfile_read;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 3;

  typedef struct packed {
    logic              v;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } resp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] indata = '0;
  logic              rsv_en = 1'b0;
  logic [ADDR_W-1:0] rsv_addr = '0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr_a = '0;
  logic [ADDR_W-1:0] rd_addr_b = '0;
  logic              stall;
  logic [DATA_W-1:0] outdata_a;
  logic [DATA_W-1:0] outdata_b;
  logic              rd_valid;

  int unsigned tests = 0;
  int unsigned fails = 0;
  resp_t       exp_q[$];
  logic        mon_en = 1'b0;

  regfile_read #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .indata(indata),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .stall(stall), .outdata_a(outdata_a), .outdata_b(outdata_b),
    .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Response monitor: each cycle's registered outputs against the scoreboard.
  always @(negedge clk) begin
    if (mon_en && exp_q.size() > 0) begin
      resp_t e;
      e = exp_q.pop_front();
      check("rd_valid", DATA_W'(rd_valid), DATA_W'(e.v));
      check("outdata_a", outdata_a, e.a);
      check("outdata_b", outdata_b, e.b);
    end
  end

  // One stimulus cycle with hand-computed stall and post-edge outputs.
  task automatic cyc(input logic we, input logic [ADDR_W-1:0] wa,
                     input logic [DATA_W-1:0] d,
                     input logic re, input logic [ADDR_W-1:0] ra,
                     input logic rd, input logic [ADDR_W-1:0] aa,
                     input logic [ADDR_W-1:0] ab,
                     input logic exp_stall, input logic exp_v,
                     input logic [DATA_W-1:0] exp_a,
                     input logic [DATA_W-1:0] exp_b);
    resp_t e;
    @(negedge clk);
    wr_en = we; wr_addr = wa; indata = d;
    rsv_en = re; rsv_addr = ra;
    rd_en = rd; rd_addr_a = aa; rd_addr_b = ab;
    #1;
    check("stall", DATA_W'(stall), DATA_W'(exp_stall));
    e.v = exp_v; e.a = exp_a; e.b = exp_b;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; rsv_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    #3;
    check("reset outdata_a", outdata_a, 32'h0);
    check("reset outdata_b", outdata_b, 32'h0);
    check("reset rd_valid", DATA_W'(rd_valid), 32'h0);
    check("reset stall", DATA_W'(stall), 32'h0);
    #4 rst_n = 1'b1;
    mon_en = 1'b1;

    //   we wa   data          re ra  rd aa ab  stl v  exp_a         exp_b
    cyc(0, 0, 32'h0,          0, 0,  1, 3, 5,  0, 1, 32'h0,        32'h0);
    cyc(0, 0, 32'h0,          0, 0,  0, 0, 0,  0, 0, 32'h0,        32'h0);
    cyc(1, 2, 32'hDEADBEEF,   0, 0,  0, 0, 0,  0, 0, 32'h0,        32'h0);
    cyc(0, 0, 32'h0,          0, 0,  1, 2, 2,  0, 1, 32'hDEADBEEF, 32'hDEADBEEF);
    cyc(1, 1, 32'h11,         0, 0,  0, 0, 0,  0, 0, 32'hDEADBEEF, 32'hDEADBEEF);
    cyc(1, 4, 32'h12345678,   0, 0,  1, 4, 1,  0, 1, 32'h12345678, 32'h11);
    cyc(0, 0, 32'h0,          1, 6,  1, 6, 1,  0, 1, 32'h0,        32'h11);
    cyc(0, 0, 32'h0,          0, 0,  1, 6, 0,  1, 0, 32'h0,        32'h11);
    cyc(0, 0, 32'h0,          0, 0,  1, 0, 6,  1, 0, 32'h0,        32'h11);
    cyc(1, 6, 32'hA5A5A5A5,   0, 0,  1, 6, 0,  0, 1, 32'hA5A5A5A5, 32'h0);
    cyc(0, 0, 32'h0,          0, 0,  1, 6, 6,  0, 1, 32'hA5A5A5A5, 32'hA5A5A5A5);
    cyc(1, 7, 32'h55,         1, 7,  0, 0, 0,  0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5);
    cyc(0, 0, 32'h0,          0, 0,  1, 7, 0,  1, 0, 32'hA5A5A5A5, 32'hA5A5A5A5);
    cyc(1, 7, 32'h66,         1, 1,  1, 7, 0,  0, 1, 32'h66,       32'h0);
    cyc(0, 0, 32'h0,          0, 0,  1, 7, 1,  1, 0, 32'h66,       32'h0);
    cyc(0, 0, 32'h0,          0, 0,  1, 7, 7,  0, 1, 32'h66,       32'h66);
    cyc(1, 0, 32'hCAFE0000,   0, 0,  0, 0, 0,  0, 0, 32'h66,       32'h66);
    cyc(0, 0, 32'h0,          0, 0,  1, 0, 7,  0, 1, 32'hCAFE0000, 32'h66);
    cyc(1, 3, 32'h99,         1, 5,  0, 0, 0,  0, 0, 32'hCAFE0000, 32'h66);

    // Asynchronous reset between edges.
    @(negedge clk);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    check("async rst outdata_a", outdata_a, 32'h0);
    check("async rst outdata_b", outdata_b, 32'h0);
    check("async rst rd_valid", DATA_W'(rd_valid), 32'h0);
    #1 rst_n = 1'b1;

    cyc(0, 0, 32'h0,          0, 0,  1, 3, 5,  0, 1, 32'h0,        32'h0);
    cyc(0, 0, 32'h0,          0, 0,  1, 5, 5,  0, 1, 32'h0,        32'h0);
    cyc(0, 0, 32'h0,          0, 0,  0, 0, 0,  0, 0, 32'h0,        32'h0);

    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
